// File: rtl/stv_edac_pkg.sv
// Shared EDAC types: scrubber FSM states, syndrome classes and the Hsiao column generator.
// The column function is elaboration-time only; all callers feed it constant arguments.
// Columns are odd-weight (>= 3) vectors taken in ascending numeric order.
package stv_edac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    CHECK,
    WR_REQ,
    NEXT
  } scrub_state_e;

  typedef enum logic [1:0] {
    CLEAN,
    CE_DATA,
    CE_PARITY,
    UE
  } syn_class_e;

  localparam int HSIAO_PMAX = 16;

  // Return the parity column assigned to data bit col_idx. Weight-1 vectors
  // are reserved for the parity bits themselves, so data columns start at weight 3.
  function automatic logic [HSIAO_PMAX-1:0] hsiao_col(input int col_idx, input int pwidth);
    logic [HSIAO_PMAX-1:0] col;
    int found;
    int w;
    logic done;
    col   = '0;
    found = 0;
    done  = 1'b0;
    for (int v = 1; v < (1 << pwidth); v++) begin
      w = 0;
      for (int b = 0; b < pwidth; b++) begin
        w += (v >> b) & 1;
      end
      if (!done && (w >= 3) && ((w % 2) == 1)) begin
        if (found == col_idx) begin
          col  = HSIAO_PMAX'(v);
          done = 1'b1;
        end
        found++;
      end
    end
    return col;
  endfunction

endpackage

// File: rtl/stv_hsiao.sv
// Hsiao parity generator: parity = XOR of the columns of every set data bit.
// Purely combinational, no latency.
// No handshake; output follows the input.
module stv_hsiao
  import stv_edac_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int PWIDTH = 7
) (
  input  logic [DWIDTH-1:0] data_i,
  output logic [PWIDTH-1:0] parity_o
);

  logic [PWIDTH-1:0] col [DWIDTH];

  for (genvar m = 0; m < DWIDTH; m++) begin : g_col
    localparam logic [HSIAO_PMAX-1:0] COL_FULL = hsiao_col(m, PWIDTH);
    assign col[m] = COL_FULL[PWIDTH-1:0];
  end

  // Accumulate the column of each set data bit.
  always_comb begin
    parity_o = '0;
    for (int m = 0; m < DWIDTH; m++) begin
      if (data_i[m]) begin
        parity_o = parity_o ^ col[m];
      end
    end
  end

endmodule

// File: rtl/stv_hsiao_decode.sv
// Hsiao SECDED decoder: classifies a stored codeword and builds its corrected form.
// Purely combinational, no latency.
// No handshake; output follows the input codeword.
module stv_hsiao_decode
  import stv_edac_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int PWIDTH = 7
) (
  input  logic [DWIDTH+PWIDTH-1:0]         cw_i,
  output syn_class_e                       syn_class_o,
  output logic [$clog2(DWIDTH+PWIDTH)-1:0] bit_idx_o,
  output logic [DWIDTH+PWIDTH-1:0]         cw_fix_o
);

  localparam int CWIDTH = DWIDTH + PWIDTH;
  localparam int IDXW   = $clog2(CWIDTH);

  logic [DWIDTH-1:0] data;
  logic [DWIDTH-1:0] fix_data;
  logic [DWIDTH-1:0] hit_mask;
  logic [PWIDTH-1:0] par;
  logic [PWIDTH-1:0] par_calc;
  logic [PWIDTH-1:0] syn;
  logic [PWIDTH-1:0] fix_par;
  logic [PWIDTH-1:0] col [DWIDTH];

  assign data = cw_i[DWIDTH-1:0];
  assign par  = cw_i[CWIDTH-1:DWIDTH];

  stv_hsiao #(.DWIDTH(DWIDTH), .PWIDTH(PWIDTH)) u_hsiao_rx (
    .data_i   (data),
    .parity_o (par_calc)
  );

  assign syn = par ^ par_calc;

  // Columns are distinct, so hit_mask is either zero or one-hot and can flip the bad bit directly.
  for (genvar m = 0; m < DWIDTH; m++) begin : g_col
    localparam logic [HSIAO_PMAX-1:0] COL_FULL = hsiao_col(m, PWIDTH);
    assign col[m]      = COL_FULL[PWIDTH-1:0];
    assign hit_mask[m] = (syn == col[m]);
  end

  assign fix_data = data ^ hit_mask;

  // Parity is always regenerated, which also repairs a single parity-bit error.
  stv_hsiao #(.DWIDTH(DWIDTH), .PWIDTH(PWIDTH)) u_hsiao_fix (
    .data_i   (fix_data),
    .parity_o (fix_par)
  );

  assign cw_fix_o = {fix_par, fix_data};

  // Classify the syndrome and report which codeword bit was in error.
  always_comb begin
    syn_class_o = CLEAN;
    bit_idx_o   = '0;
    if (syn == '0) begin
      syn_class_o = CLEAN;
    end else if (|hit_mask) begin
      syn_class_o = CE_DATA;
      for (int m = 0; m < DWIDTH; m++) begin
        if (hit_mask[m]) begin
          bit_idx_o = IDXW'(m);
        end
      end
    end else if ($onehot(syn)) begin
      syn_class_o = CE_PARITY;
      for (int p = 0; p < PWIDTH; p++) begin
        if (syn[p]) begin
          bit_idx_o = IDXW'(DWIDTH + p);
        end
      end
    end else begin
      syn_class_o = UE;
    end
  end

endmodule

// File: rtl/stv_ecc_scrubber.sv
// Background SECDED scrubber: reads every word, writes back single-bit fixes, flags uncorrectables.
// Per word: INTERVAL idle cycles + 4 (clean/UE) or 5 (CE) with immediate grant and 1-cycle rvalid.
// Requests hold address/we stable until mem_gnt; never withdrawn before grant except by reset.
module stv_ecc_scrubber
  import stv_edac_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int PWIDTH   = 7,
  parameter int DEPTH    = 1024,
  parameter int INTERVAL = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  output logic                       mem_req,
  input  logic                       mem_gnt,
  output logic                       mem_we,
  output logic [$clog2(DEPTH)-1:0]   mem_addr,
  output logic [DWIDTH+PWIDTH-1:0]   mem_wdata,
  input  logic                       mem_rvalid,
  input  logic [DWIDTH+PWIDTH-1:0]   mem_rdata,
  output logic                       ce_pulse,
  output logic                       ue_pulse,
  output logic [$clog2(DEPTH)-1:0]   err_addr,
  output logic [15:0]                ce_count,
  output logic [15:0]                ue_count,
  output logic                       sweep_done
);

  localparam int AWIDTH = $clog2(DEPTH);
  localparam int CWIDTH = DWIDTH + PWIDTH;
  localparam int IDXW   = $clog2(CWIDTH);
  localparam int TWIDTH = $clog2(INTERVAL + 1);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);
  localparam logic [TWIDTH-1:0] TIMER_END = TWIDTH'(INTERVAL - 1);

  if (PWIDTH < 1 + $clog2(DWIDTH + PWIDTH)) begin : g_bad_pwidth
    $error("stv_ecc_scrubber: PWIDTH too small for SECDED over DWIDTH+PWIDTH bits");
  end
  if (INTERVAL < 1) begin : g_bad_interval
    $error("stv_ecc_scrubber: INTERVAL must be at least 1");
  end

  scrub_state_e      state_q;
  logic [AWIDTH-1:0] addr_q;
  logic [AWIDTH-1:0] addr_d;
  logic [TWIDTH-1:0] timer_q;
  logic [CWIDTH-1:0] cw_q;
  logic              req_q;
  logic              we_q;
  logic [CWIDTH-1:0] wdata_q;
  logic              ce_pulse_q;
  logic              ue_pulse_q;
  logic [AWIDTH-1:0] err_addr_q;
  logic [15:0]       ce_count_q;
  logic [15:0]       ce_count_d;
  logic [15:0]       ue_count_q;
  logic [15:0]       ue_count_d;
  logic              sweep_done_q;

  syn_class_e        dec_class;
  logic [IDXW-1:0]   dec_idx_unused;
  logic [CWIDTH-1:0] dec_cw_fix;

  // Decode runs off the registered codeword so CHECK is a single clean cycle.
  stv_hsiao_decode #(.DWIDTH(DWIDTH), .PWIDTH(PWIDTH)) u_decode (
    .cw_i        (cw_q),
    .syn_class_o (dec_class),
    .bit_idx_o   (dec_idx_unused),
    .cw_fix_o    (dec_cw_fix)
  );

  assign addr_d     = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
  assign ce_count_d = (ce_count_q == 16'hFFFF) ? ce_count_q : ce_count_q + 16'd1;
  assign ue_count_d = (ue_count_q == 16'hFFFF) ? ue_count_q : ue_count_q + 16'd1;

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign ce_pulse   = ce_pulse_q;
  assign ue_pulse   = ue_pulse_q;
  assign err_addr   = err_addr_q;
  assign ce_count   = ce_count_q;
  assign ue_count   = ue_count_q;
  assign sweep_done = sweep_done_q;

  // Scrub FSM with registered request, write data, pulses and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      timer_q      <= '0;
      cw_q         <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      ce_pulse_q   <= 1'b0;
      ue_pulse_q   <= 1'b0;
      err_addr_q   <= '0;
      ce_count_q   <= '0;
      ue_count_q   <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      ce_pulse_q   <= 1'b0;
      ue_pulse_q   <= 1'b0;
      sweep_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!enable) begin
            timer_q <= '0;
          end else if (timer_q == TIMER_END) begin
            timer_q <= '0;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            state_q <= RD_REQ;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RD_REQ: begin
          if (mem_gnt) begin
            req_q   <= 1'b0;
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_rvalid) begin
            cw_q    <= mem_rdata;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          case (dec_class)
            CLEAN: begin
              state_q <= NEXT;
            end
            CE_DATA, CE_PARITY: begin
              ce_pulse_q <= 1'b1;
              ce_count_q <= ce_count_d;
              err_addr_q <= addr_q;
              wdata_q    <= dec_cw_fix;
              req_q      <= 1'b1;
              we_q       <= 1'b1;
              state_q    <= WR_REQ;
            end
            default: begin
              ue_pulse_q <= 1'b1;
              ue_count_q <= ue_count_d;
              err_addr_q <= addr_q;
              state_q    <= NEXT;
            end
          endcase
        end
        WR_REQ: begin
          if (mem_gnt) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= NEXT;
          end
        end
        NEXT: begin
          addr_q       <= addr_d;
          sweep_done_q <= (addr_q == LAST_ADDR);
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stv_ecc_scrubber.sv
// Directed bench for stv_ecc_scrubber: clean sweep, CE data/parity, UE, withheld grant, reset in RD_WAIT.
// A small RAM responder answers reads one cycle after grant and logs every transfer and pulse.
// Expected codewords use Hsiao columns col0=7'h07, col1=7'h0B, col5=7'h15.
module tb_stv_ecc_scrubber;

  localparam int DW       = 32;
  localparam int PW       = 7;
  localparam int DEPTH    = 8;
  localparam int INTERVAL = 4;
  localparam int AW       = 3;
  localparam int CW       = DW + PW;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          mem_req;
  logic          mem_gnt;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_wdata;
  logic          mem_rvalid;
  logic [CW-1:0] mem_rdata;
  logic          ce_pulse;
  logic          ue_pulse;
  logic [AW-1:0] err_addr;
  logic [15:0]   ce_count;
  logic [15:0]   ue_count;
  logic          sweep_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // responder controls and logs
  bit            auto_rsp  = 1'b1;
  bit            seed_errs = 1'b0;
  bit            seeded    = 1'b0;
  logic          inj_vld   = 1'b0;
  logic [CW-1:0] inj_dat   = '0;
  logic [CW-1:0] ram [DEPTH];
  int            rd_n = 0, wr_n = 0, ce_n = 0, ue_n = 0;
  logic [AW-1:0] rd_addr_log [32];
  int            rd_cyc_log  [32];
  logic [AW-1:0] wr_addr_log [32];
  logic [CW-1:0] wr_data_log [32];
  logic [AW-1:0] ce_addr_log [32];
  logic [15:0]   ce_val_log  [32];
  logic [AW-1:0] ue_addr_log [32];

  always #5 clk = ~clk;

  stv_ecc_scrubber #(
    .DWIDTH(DW), .PWIDTH(PW), .DEPTH(DEPTH), .INTERVAL(INTERVAL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .ce_pulse   (ce_pulse),
    .ue_pulse   (ue_pulse),
    .err_addr   (err_addr),
    .ce_count   (ce_count),
    .ue_count   (ue_count),
    .sweep_done (sweep_done)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // RAM responder: sample transfer at negedge, complete it just after the next posedge.
  initial begin
    logic          pend;
    logic          pwe;
    logic [AW-1:0] padr;
    logic [CW-1:0] pdat;
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (ce_pulse === 1'b1) begin
        ce_addr_log[ce_n % 32] = err_addr;
        ce_val_log[ce_n % 32]  = ce_count;
        ce_n++;
      end
      if (ue_pulse === 1'b1) begin
        ue_addr_log[ue_n % 32] = err_addr;
        ue_n++;
      end
      pend = (mem_req === 1'b1) && (mem_gnt === 1'b1);
      pwe  = mem_we;
      padr = mem_addr;
      pdat = mem_wdata;
      @(posedge clk);
      #1;
      if (seed_errs && !seeded) begin
        ram[2] = {7'h00, 32'h0000_0003};   // data bits 0,1 flipped from all-zero
        ram[3] = {7'h12, 32'h0000_0001};   // original {12,00000021}, data bit 5 flipped
        ram[6] = {7'h03, 32'h0000_0001};   // original {07,00000001}, parity bit 2 flipped
        seeded = 1'b1;
      end
      mem_rvalid = auto_rsp ? 1'b0 : inj_vld;
      if (!auto_rsp) mem_rdata = inj_dat;
      if (pend) begin
        if (pwe) begin
          ram[padr] = pdat;
          wr_addr_log[wr_n % 32] = padr;
          wr_data_log[wr_n % 32] = pdat;
          wr_n++;
        end else begin
          rd_addr_log[rd_n % 32] = padr;
          rd_cyc_log[rd_n % 32]  = cyc;
          rd_n++;
          if (auto_rsp) begin
            mem_rvalid = 1'b1;
            mem_rdata  = ram[padr];
          end
        end
      end
    end
  end

  initial begin
    int rb, wb, cb, ub, n;
    rst     = 1'b1;
    enable  = 1'b0;
    mem_gnt = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_req_we", {mem_req, mem_we}, 2'b00);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_counts", {ce_count, ue_count}, 32'h0);
    check_val("rst_err_addr", err_addr, 0);
    check_val("rst_pulses", {ce_pulse, ue_pulse, sweep_done}, 3'b000);
    rst = 1'b0;

    // clean sweep
    rb = rd_n; wb = wr_n;
    enable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (sweep_done !== 1'b1 && n < 300);
    check_val("sw1_done", sweep_done, 1);
    enable = 1'b0;
    check_val("sw1_reads", rd_n - rb, 8);
    for (int i = 0; i < 8; i++) check_val($sformatf("sw1_rd%0d", i), rd_addr_log[(rb + i) % 32], i);
    check_val("sw1_spacing", rd_cyc_log[(rb + 1) % 32] - rd_cyc_log[rb % 32], 8);
    check_val("sw1_writes", wr_n - wb, 0);
    check_val("sw1_counts", {ce_count, ue_count}, 32'h0);
    check_val("sw1_wrap", mem_addr, 0);
    @(negedge clk);
    check_val("sw1_done_1cyc", sweep_done, 0);

    // sweep with CE data, CE parity and UE words
    seed_errs = 1'b1;
    repeat (2) @(negedge clk);
    rb = rd_n; wb = wr_n; cb = ce_n; ub = ue_n;
    enable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (sweep_done !== 1'b1 && n < 300);
    check_val("sw2_done", sweep_done, 1);
    enable = 1'b0;
    check_val("sw2_writes", wr_n - wb, 2);
    check_val("sw2_wr0_addr", wr_addr_log[wb % 32], 3);
    check_val("sw2_wr0_data", wr_data_log[wb % 32], {7'h12, 32'h0000_0021});
    check_val("sw2_wr1_addr", wr_addr_log[(wb + 1) % 32], 6);
    check_val("sw2_wr1_data", wr_data_log[(wb + 1) % 32], {7'h07, 32'h0000_0001});
    check_val("sw2_ce_pulses", ce_n - cb, 2);
    check_val("sw2_ce0_addr", ce_addr_log[cb % 32], 3);
    check_val("sw2_ce0_count", ce_val_log[cb % 32], 1);
    check_val("sw2_ce1_addr", ce_addr_log[(cb + 1) % 32], 6);
    check_val("sw2_ce1_count", ce_val_log[(cb + 1) % 32], 2);
    check_val("sw2_ue_pulses", ue_n - ub, 1);
    check_val("sw2_ue_addr", ue_addr_log[ub % 32], 2);
    check_val("sw2_counts", {ce_count, ue_count}, {16'd2, 16'd1});
    check_val("sw2_err_addr", err_addr, 6);
    check_val("sw2_ue_untouched", ram[2], {7'h00, 32'h0000_0003});
    check_val("sw2_ue_spacing", rd_cyc_log[(rb + 3) % 32] - rd_cyc_log[(rb + 2) % 32], 8);
    check_val("sw2_ce_spacing", rd_cyc_log[(rb + 4) % 32] - rd_cyc_log[(rb + 3) % 32], 9);

    // grant withheld for 10 cycles
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    enable  = 1'b1;
    rb = rd_n;
    n = 0;
    do begin @(negedge clk); n++; end while (mem_req !== 1'b1 && n < 50);
    check_val("gw_req_seen", mem_req, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val($sformatf("gw_hold%0d", i), {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 3'd0});
    end
    check_val("gw_no_xfer", rd_n - rb, 0);
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    enable  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("gw_req_drop", mem_req, 0);
    check_val("gw_xfer", rd_n - rb, 1);
    check_val("gw_addr", rd_addr_log[rb % 32], 0);
    repeat (8) @(negedge clk);
    check_val("gw_park", {mem_req, mem_addr}, {1'b0, 3'd1});

    // reset while in RD_WAIT, late rvalid must be ignored
    @(negedge clk);
    auto_rsp = 1'b0;
    enable   = 1'b1;
    ub = ue_n; cb = ce_n;
    n = 0;
    do begin @(negedge clk); n++; end while (mem_req !== 1'b1 && n < 50);
    check_val("rw_req_seen", mem_req, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("rw_req", mem_req, 0);
    check_val("rw_addr", mem_addr, 0);
    check_val("rw_counts", {ce_count, ue_count}, 32'h0);
    check_val("rw_err_addr", err_addr, 0);
    inj_vld = 1'b1;
    inj_dat = {7'h00, 32'h0000_0003};
    @(negedge clk);
    inj_vld  = 1'b0;
    auto_rsp = 1'b1;
    rb = rd_n;
    n = 0;
    do begin @(negedge clk); n++; end while (rd_n == rb && n < 50);
    check_val("rw_next_read", rd_n - rb, 1);
    check_val("rw_next_addr", rd_addr_log[rb % 32], 0);
    repeat (6) @(negedge clk);
    check_val("rw_no_pulses", (ue_n - ub) + (ce_n - cb), 0);
    check_val("rw_counts_end", {ce_count, ue_count}, 32'h0);
    check_val("rw_err_addr_end", err_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stv_ecc_scrubber.md
# stv_ecc_scrubber

Background memory scrubber for Hsiao-SECDED-protected RAMs. It walks every address, reads each stored codeword, and recomputes the syndrome with the team's Hsiao generator. Single-bit errors are corrected and written back; uncorrectable errors are flagged. It sits beside the functional ECC path and shares the RAM port through an external arbiter, using a req/gnt handshake.

## Interface
- DWIDTH, 32: data bits per word.
- PWIDTH, 7: Hsiao parity bits. Elaboration fails unless PWIDTH >= 1 + $clog2(DWIDTH+PWIDTH).
- DEPTH, 1024: words in the RAM. AWIDTH = $clog2(DEPTH).
- INTERVAL, 256: idle cycles between scrub accesses. Must be >= 1.
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  scrubbing allowed. Sampled only in IDLE.
- mem_req  out  1  access request to the arbiter.
- mem_gnt  in  1  arbiter grant. Transfer occurs when mem_req && mem_gnt.
- mem_we  out  1  1 = write-back, 0 = read.
- mem_addr  out  AWIDTH  access address.
- mem_wdata  out  DWIDTH+PWIDTH  corrected codeword {parity, data}.
- mem_rvalid  in  1  read data valid. Arrives one or more cycles after the read transfer.
- mem_rdata  in  DWIDTH+PWIDTH  stored codeword {parity, data}.
- ce_pulse  out  1  one-cycle flag: correctable error found.
- ue_pulse  out  1  one-cycle flag: uncorrectable error found.
- err_addr  out  AWIDTH  address of the most recent CE or UE.
- ce_count  out  16  saturating count of correctable errors.
- ue_count  out  16  saturating count of uncorrectable errors.
- sweep_done  out  1  one-cycle pulse after address DEPTH-1 completes.

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT.
- IDLE: the interval timer counts up while enable=1. When it reaches INTERVAL-1, go to RD_REQ and clear the timer. If enable=0, the timer holds at 0.
- RD_REQ: mem_req=1, mem_we=0, mem_addr=addr. Hold until mem_gnt, then go to RD_WAIT. mem_addr and mem_we stay stable while mem_req=1; the request is never withdrawn before grant.
- RD_WAIT: on mem_rvalid, register the codeword and go to CHECK. mem_rvalid outside RD_WAIT is ignored.
- CHECK: compute the syndrome = stored parity XOR hsiao(data), then classify:
  - syndrome 0: clean. Go to NEXT.
  - syndrome equals a data column m: flip data bit m, recompute parity, raise CE, go to WR_REQ.
  - syndrome is one-hot (parity bit error): rewrite with recomputed parity, raise CE, go to WR_REQ.
  - any other nonzero syndrome (even weight, or odd weight not matching a column): raise UE, no write, go to NEXT.
- WR_REQ: mem_req=1, mem_we=1, mem_wdata = corrected codeword. Hold until mem_gnt, then go to NEXT.
- NEXT: increment addr. At DEPTH-1, wrap to 0 and pulse sweep_done. Then go to IDLE.
- When ce_pulse or ue_pulse fires, err_addr updates on the same edge.
- Counters saturate at 16'hFFFF.
- enable deasserted mid-access does not abort; the current access completes and the block then parks in IDLE.

## Timing
- Reset values: state=IDLE, addr=0, timer=0, all outputs 0, both counters 0.
- A reset mid-operation aborts immediately, including an ungranted request. mem_req falls in the cycle after the reset edge.
- CHECK is a single cycle. The syndrome decode is purely combinational from the registered codeword.
- ce_pulse and ue_pulse are registered and assert in the cycle after CHECK, together with the counter update.
- Clean word with immediate gnt and rvalid one cycle after grant: RD_REQ → RD_WAIT → CHECK → NEXT → IDLE. That is 4 cycles, plus INTERVAL cycles in IDLE.
- CE word with immediate grants: 5 cycles, plus INTERVAL.
- A grant arriving while mem_req=0 is ignored.

## Structure
- The shared package stv_edac_pkg holds:
  - the state enum,
  - the syndrome-class enum (CLEAN, CE_DATA, CE_PARITY, UE),
  - the Hsiao column function already used by the generator.
- One sub-module, stv_hsiao_decode. It is combinational. It takes the codeword and returns syndrome class, bit index, and the corrected codeword. Internally it instantiates stv_hsiao for parity recomputation.
- The FSM, timer, address counter, and error counters live in stv_ecc_scrubber.

## Test plan
- Clean RAM, INTERVAL=4, DEPTH=8, always-grant: 8 reads, no writes, sweep_done after address 7, addr wraps to 0, counters stay 0.
- Data bit 5 flipped at address 3: one write to address 3 with the original codeword, ce_pulse once, err_addr=3, ce_count=1.
- Parity bit 2 flipped at address 6: write-back restores the parity, ce_count increments, data unchanged.
- Data bits 0 and 1 flipped at address 2: ue_pulse, err_addr=2, no write issued, ue_count=1.
- mem_gnt withheld for 10 cycles during RD_REQ: mem_req, mem_addr, and mem_we stay stable; the transfer completes on the grant cycle.
- rst asserted during RD_WAIT; mem_rvalid arrives after reset: the rvalid is ignored, state=IDLE, addr=0, counters 0.
